// File: rtl/hazard_unit.sv
// hazard_unit -- stall/flush controller for the five-stage pipeline.
//
// Drives the enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
// latches plus the PC enable. Cache waits, load-use hazards, taken branches
// and HALT are resolved with a fixed priority. A RUN/HALTED state machine
// makes halt sticky until reset, and three 32-bit counters track cycles,
// stall cycles and flush events.
//
// Ports:
//   CLK, nRST                 clock (rising edge), async active-low reset
//   ihit, dhit                instruction / data access complete this cycle
//   mem_req                   MEM-stage instruction reads or writes memory
//   halt_in                   MEM-stage instruction is HALT
//   br_taken                  branch/jump resolved taken in MEM
//   id_rs, id_rt              ID-stage source registers
//   ex_dREN, ex_dest          ID/EX latch load flag and destination register
//   clr_counts                synchronous clear of all counters
//   pc_en                     PC update enable
//   fetch_en, fetch_flush     IF/ID latch control
//   decode_en, decode_flush   ID/EX latch control
//   exec_en, exec_flush       EX/MEM latch control
//   mem_en                    MEM/WB latch enable
//   halted                    pipeline halted (sticky)
//   cycle_count, stall_count, flush_count   performance counters
module hazard_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_req,
  input  logic        halt_in,
  input  logic        br_taken,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_dREN,
  input  logic [4:0]  ex_dest,
  input  logic        clr_counts,
  output logic        pc_en,
  output logic        fetch_en,
  output logic        fetch_flush,
  output logic        decode_en,
  output logic        decode_flush,
  output logic        exec_en,
  output logic        exec_flush,
  output logic        mem_en,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state, next_state;

  logic dstall;
  logic lu;
  logic stall_ev;
  logic flush_ev;

  assign dstall = mem_req & ~dhit;
  assign lu     = ex_dREN & (ex_dest != 5'd0) &
                  ((ex_dest == id_rs) | (ex_dest == id_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Exactly one rule applies per cycle; stall_ev/flush_ev select the single
  // counter event that goes with it.
  always_comb begin
    next_state   = state;
    pc_en        = 1'b1;
    fetch_en     = 1'b1;
    fetch_flush  = 1'b0;
    decode_en    = 1'b1;
    decode_flush = 1'b0;
    exec_en      = 1'b1;
    exec_flush   = 1'b0;
    mem_en       = 1'b1;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;

    if (state == HALTED) begin
      pc_en     = 1'b0;
      fetch_en  = 1'b0;
      decode_en = 1'b0;
      exec_en   = 1'b0;
      mem_en    = 1'b0;
    end else if (dstall) begin
      pc_en     = 1'b0;
      fetch_en  = 1'b0;
      decode_en = 1'b0;
      exec_en   = 1'b0;
      mem_en    = 1'b0;
      stall_ev  = 1'b1;
    end else if (halt_in) begin
      // Let HALT retire into MEM/WB, freeze everything behind it.
      pc_en      = 1'b0;
      fetch_en   = 1'b0;
      decode_en  = 1'b0;
      exec_en    = 1'b0;
      next_state = HALTED;
    end else if (br_taken) begin
      // PC loads the target regardless of ihit; the three younger
      // instructions are squashed.
      fetch_en     = 1'b0;
      fetch_flush  = 1'b1;
      decode_en    = 1'b0;
      decode_flush = 1'b1;
      exec_en      = 1'b0;
      exec_flush   = 1'b1;
      flush_ev     = 1'b1;
    end else if (lu) begin
      // Hold PC and IF/ID, insert one bubble into ID/EX.
      pc_en        = 1'b0;
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      decode_flush = 1'b1;
      stall_ev     = 1'b1;
    end else if (!ihit) begin
      pc_en       = 1'b0;
      fetch_en    = 1'b0;
      fetch_flush = 1'b1;
      stall_ev    = 1'b1;
    end
  end

  assign halted = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cycle_count <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (clr_counts) begin
      cycle_count <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (state == RUN) begin
      cycle_count <= cycle_count + 32'd1;
      if (stall_ev) begin
        stall_count <= stall_count + 32'd1;
      end
      if (flush_ev) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, mem_req, halt_in, br_taken;
  logic [4:0]  id_rs, id_rt, ex_dest;
  logic        ex_dREN, clr_counts;
  logic        pc_en, fetch_en, fetch_flush, decode_en, decode_flush;
  logic        exec_en, exec_flush, mem_en, halted;
  logic [31:0] cycle_count, stall_count, flush_count;

  hazard_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .halt_in(halt_in), .br_taken(br_taken), .id_rs(id_rs), .id_rt(id_rt),
    .ex_dREN(ex_dREN), .ex_dest(ex_dest), .clr_counts(clr_counts),
    .pc_en(pc_en), .fetch_en(fetch_en), .fetch_flush(fetch_flush),
    .decode_en(decode_en), .decode_flush(decode_flush),
    .exec_en(exec_en), .exec_flush(exec_flush), .mem_en(mem_en),
    .halted(halted), .cycle_count(cycle_count),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_halt;
  logic [31:0] m_cyc, m_stl, m_fls;

  // event classes, in priority order
  localparam int EV_HALTED = 0, EV_DSTALL = 1, EV_HALT = 2, EV_BR = 3,
                 EV_LU = 4, EV_IMISS = 5, EV_NONE = 6;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int classify();
    bit lu_now;
    lu_now = ex_dREN && (ex_dest != 0) && (ex_dest == id_rs || ex_dest == id_rt);
    if (m_halt)                return EV_HALTED;
    if (mem_req && !dhit)      return EV_DSTALL;
    if (halt_in)               return EV_HALT;
    if (br_taken)              return EV_BR;
    if (lu_now)                return EV_LU;
    if (!ihit)                 return EV_IMISS;
    return EV_NONE;
  endfunction

  // {pc_en, fetch_en, fetch_flush, decode_en, decode_flush, exec_en, exec_flush, mem_en}
  function automatic logic [7:0] ctl_for(input int ev);
    case (ev)
      EV_HALTED, EV_DSTALL: return 8'b0000_0000;
      EV_HALT:              return 8'b0000_0001;
      EV_BR:                return 8'b1010_1011;
      EV_LU:                return 8'b0000_1101;
      EV_IMISS:             return 8'b0011_0101;
      default:              return 8'b1101_0101;
    endcase
  endfunction

  function automatic logic [7:0] dut_ctl();
    return {pc_en, fetch_en, fetch_flush, decode_en, decode_flush,
            exec_en, exec_flush, mem_en};
  endfunction

  task automatic idle_inputs();
    ihit = 1; dhit = 0; mem_req = 0; halt_in = 0; br_taken = 0;
    id_rs = 0; id_rt = 0; ex_dREN = 0; ex_dest = 0; clr_counts = 0;
  endtask

  // Called away from the clock edge with inputs already driven.
  task automatic step();
    int ev;
    #1;
    ev = classify();
    check("ctl", {24'd0, dut_ctl()}, {24'd0, ctl_for(ev)});
    check("halted_pre", {31'd0, halted}, {31'd0, m_halt});
    @(posedge CLK);
    if (clr_counts) begin
      m_cyc = 0; m_stl = 0; m_fls = 0;
    end else if (!m_halt) begin
      m_cyc = m_cyc + 1;
      if (ev == EV_DSTALL || ev == EV_LU || ev == EV_IMISS) m_stl = m_stl + 1;
      if (ev == EV_BR) m_fls = m_fls + 1;
    end
    if (ev == EV_HALT) m_halt = 1;
    #1;
    check("cycle_count", cycle_count, m_cyc);
    check("stall_count", stall_count, m_stl);
    check("flush_count", flush_count, m_fls);
    check("halted", {31'd0, halted}, {31'd0, m_halt});
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset();
    nRST = 0;
    #2;
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_stall", stall_count, 32'd0);
    check("rst_flush", flush_count, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    nRST = 1;
    m_halt = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
  endtask

  initial begin
    logic [31:0] frozen;
    idle_inputs();
    m_halt = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
    nRST = 0;
    #3;
    check("reset_cycle", cycle_count, 32'd0);
    check("reset_stall", stall_count, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    @(negedge CLK);
    nRST = 1;

    // free run
    for (int i = 0; i < 10; i++) step();
    check("free_cycle10", cycle_count, 32'd10);
    check("free_stall0", stall_count, 32'd0);

    // load-use
    ex_dREN = 1; ex_dest = 5; id_rt = 5;
    step();
    check("lu_stall", stall_count, 32'd1);
    ex_dest = 0; id_rt = 0;
    step();
    check("lu_r0_nostall", stall_count, 32'd1);
    ex_dREN = 0;

    // dstall with branch pending, then dhit
    mem_req = 1; dhit = 0; br_taken = 1;
    for (int i = 0; i < 3; i++) step();
    check("dstall_stall", stall_count, 32'd4);
    dhit = 1;
    step();
    check("dstall_br_flush", flush_count, 32'd1);
    mem_req = 0; dhit = 0;

    // branch beats load-use and imiss
    ex_dREN = 1; ex_dest = 7; id_rs = 7; ihit = 0;
    step();
    check("br_prio_flush", flush_count, 32'd2);
    check("br_prio_stall", stall_count, 32'd4);
    idle_inputs();

    // reset mid-stall
    mem_req = 1;
    step();
    pulse_reset();
    idle_inputs();
    step();

    // halt, freeze, clear, reset
    halt_in = 1;
    step();
    halt_in = 0;
    check("halt_sticky", {31'd0, halted}, 32'd1);
    frozen = cycle_count;
    for (int i = 0; i < 5; i++) begin
      ihit = 1'($urandom); br_taken = 1'($urandom); halt_in = 1'($urandom);
      step();
    end
    idle_inputs();
    check("halt_frozen", cycle_count, frozen);
    clr_counts = 1;
    step();
    clr_counts = 0;
    check("halt_clr", cycle_count, 32'd0);
    pulse_reset();

    // clear coincident with a stall
    ihit = 0; step();
    ihit = 0; clr_counts = 1; step();
    check("clr_vs_stall", stall_count, 32'd0);
    idle_inputs();

    // randomized run
    for (int i = 0; i < 600; i++) begin
      ihit       = ($urandom % 4) != 0;
      mem_req    = ($urandom % 3) == 0;
      dhit       = 1'($urandom);
      halt_in    = ($urandom % 60) == 0;
      br_taken   = ($urandom % 6) == 0;
      ex_dREN    = ($urandom % 3) == 0;
      ex_dest    = 5'($urandom % 4);
      id_rs      = 5'($urandom % 4);
      id_rt      = 5'($urandom % 4);
      clr_counts = ($urandom % 40) == 0;
      step();
      if (m_halt && ($urandom % 6) == 0) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Central stall/flush controller for the five-stage pipeline. It drives the enable and flush inputs of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It resolves cache waits, load-use hazards, taken branches and halt with a fixed priority, and keeps a small run/halt state machine plus performance counters. It sits beside the datapath; the latches sample its outputs on the same rising edge.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_req  in  1  instruction in MEM stage has dREN or dWEN set
- halt_in  in  1  instruction in MEM stage is HALT
- br_taken  in  1  branch/jump resolved taken in MEM stage
- id_rs, id_rt  in  5 each  source registers of instruction in ID stage
- ex_dREN  in  1  dRENOUT of the ID/EX latch
- ex_dest  in  5  resolved destination register of the ID/EX latch
- clr_counts  in  1  synchronous counter clear
- pc_en  out  1  PC update enable
- fetch_en, fetch_flush  out  1 each  IF/ID latch control
- decode_en, decode_flush  out  1 each  ID/EX latch control
- exec_en, exec_flush  out  1 each  EX/MEM latch control
- mem_en  out  1  MEM/WB latch enable
- halted  out  1  pipeline halted (sticky)
- cycle_count, stall_count, flush_count  out  32 each  performance counters

## Operation
- States: RUN and HALTED. Reset enters RUN.
- Derived terms:
  - dstall = mem_req & ~dhit
  - lu = ex_dREN & (ex_dest != 0) & (ex_dest == id_rs | ex_dest == id_rt)
- Control outputs are combinational (Mealy) from state and inputs. Defaults: every en = 1, every flush = 0. Whenever a latch's flush = 1, its en = 0.
- RUN rules, evaluated in priority order; the first match applies:
  1. dstall: every en = 0, every flush = 0; stall_count += 1.
  2. halt_in: mem_en = 1, all other en = 0, all flush = 0; next state HALTED.
  3. br_taken: pc_en = 1; fetch_flush, decode_flush and exec_flush = 1; mem_en = 1; flush_count += 1. Branch wins over lu and ~ihit. PC loads the target even if ihit = 0.
  4. lu: pc_en = 0, fetch_en = 0, decode_flush = 1 (one bubble into ID/EX), exec_en = 1, mem_en = 1; stall_count += 1.
  5. ~ihit: pc_en = 0, fetch_flush = 1, decode_en = exec_en = mem_en = 1; stall_count += 1.
  6. Otherwise, defaults apply.
- HALTED: every en = 0, every flush = 0, halted = 1. The state is left only through nRST. All inputs are ignored.
- Counters:
  - cycle_count += 1 on every RUN cycle, including stall cycles. It is frozen in HALTED.
  - All counters wrap modulo 2^32.
  - clr_counts zeroes all three on the next edge and wins over a simultaneous increment. clr_counts is honored in HALTED too.
- Only one counter event is counted per cycle, chosen by the priority above.

## Timing
- Reset values: state RUN, all counters 0, halted 0.
  - Control outputs are combinational, so during reset they follow the RUN rules on current inputs.
- Zero-cycle latency: control outputs react to inputs in the same cycle. Counters and state update on the rising edge.
- Load-use costs exactly 1 cycle. The next cycle, the load has moved to EX/MEM and ex_dREN refers to the bubble, so lu drops.
- Branch penalty is 3 squashed instructions (IF/ID, ID/EX, EX/MEM).
- dstall holding for N cycles freezes the whole pipe for N cycles and adds N to stall_count. A br_taken or halt_in held during that time takes effect in the first cycle with dhit = 1.
- halted rises on the edge after the halt_in cycle (when not dstall).
- Reset asserted mid-stall or in HALTED returns to RUN with zeroed counters immediately (asynchronous).

## Test plan
- Reset then free run (ihit = 1, no hazards) for 10 cycles -> every en = 1, every flush = 0; cycle_count = 10, stall_count = 0, flush_count = 0.
- ex_dREN = 1, ex_dest = 5, id_rt = 5 for one cycle -> pc_en = 0, fetch_en = 0, decode_flush = 1, stall_count = 1. Repeat with ex_dest = 0 -> no stall.
- mem_req = 1, dhit = 0 for 3 cycles with br_taken = 1 -> all en = 0 for 3 cycles, stall_count = 3. On the dhit = 1 cycle: three flushes asserted, flush_count = 1.
- br_taken = 1 with lu = 1 and ihit = 0 simultaneously -> branch response only: pc_en = 1, flush_count += 1, stall_count unchanged.
- halt_in = 1 -> that cycle mem_en = 1, others 0. Next edge halted = 1. 5 further cycles -> cycle_count frozen. Then clr_counts -> all counters 0. Then nRST pulse -> halted = 0.
- Preload cycle_count near 0xFFFFFFFF via a long run (or force), run past it -> cycle_count wraps to 0. clr_counts coincident with a stall -> stall_count = 0.
